// File: rtl/issue_queue_int.sv
// issue_queue_int
//   Integer issue queue in front of the integer physical register file.
//   Holds dispatched micro-ops until both source operands are ready. Writeback
//   tag broadcasts wake the sources. Up to WAYS ready micro-ops are selected per
//   cycle, oldest first, and registered onto the issue ports.
//
// Ports
//   clock, reset          clock; synchronous active-high reset
//   flush                 synchronous flush: empties queue, clears iss_valid
//   dis_*                 WAYS dispatch lanes (lane 0 older); dis_ready = room
//                         for a full group
//   wb_valid / wb_index   WAYS writeback tag broadcasts
//   iss_stall             hold issue registers, select nothing
//   iss_*                 registered issue slots (slot 0 older)
//   free_count            free entries at the start of the cycle
module issue_queue_int #(
  parameter int unsigned ENTRIES   = 8,
  parameter int unsigned WAYS      = 2,
  parameter int unsigned PREG_W    = 6,
  parameter int unsigned PAYLOAD_W = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [WAYS-1:0]               dis_valid,
  input  logic [WAYS*PREG_W-1:0]        dis_rs1,
  input  logic [WAYS*PREG_W-1:0]        dis_rs2,
  input  logic [WAYS*PREG_W-1:0]        dis_rd,
  input  logic [WAYS-1:0]               dis_rs1_ready,
  input  logic [WAYS-1:0]               dis_rs2_ready,
  input  logic [WAYS*PAYLOAD_W-1:0]     dis_payload,
  output logic                          dis_ready,
  input  logic [WAYS-1:0]               wb_valid,
  input  logic [WAYS*PREG_W-1:0]        wb_index,
  input  logic                          iss_stall,
  output logic [WAYS-1:0]               iss_valid,
  output logic [WAYS*PREG_W-1:0]        iss_rs1_index,
  output logic [WAYS*PREG_W-1:0]        iss_rs2_index,
  output logic [WAYS*PREG_W-1:0]        iss_rd_index,
  output logic [WAYS*PAYLOAD_W-1:0]     iss_payload,
  output logic [$clog2(ENTRIES+1)-1:0]  free_count
);

  localparam int unsigned CNT_W = $clog2(ENTRIES + 1);
  localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  // Entry storage
  logic [ENTRIES-1:0]   r_valid;
  logic [ENTRIES-1:0]   r_rs1_rdy;
  logic [ENTRIES-1:0]   r_rs2_rdy;
  logic [PREG_W-1:0]    r_rs1     [ENTRIES];
  logic [PREG_W-1:0]    r_rs2     [ENTRIES];
  logic [PREG_W-1:0]    r_rd      [ENTRIES];
  logic [PAYLOAD_W-1:0] r_payload [ENTRIES];
  // r_age[i][j] = 1 : entry j is older than entry i
  logic [ENTRIES-1:0]   r_age     [ENTRIES];

  logic [CNT_W-1:0]     w_used;
  logic [CNT_W-1:0]     w_free;
  logic                 w_dis_ready;
  logic [ENTRIES-1:0]   w_ready;
  logic [WAYS-1:0]      w_sel_vld;
  logic [IDX_W-1:0]     w_sel_idx  [WAYS];
  logic [ENTRIES-1:0]   w_sel_mask;
  logic [WAYS-1:0]      w_dis_en;
  logic [IDX_W-1:0]     w_dis_idx  [WAYS];
  logic [ENTRIES-1:0]   w_dis_older[WAYS];
  logic [WAYS-1:0]      w_dis_rs1_rdy;
  logic [WAYS-1:0]      w_dis_rs2_rdy;

  // Occupancy
  always_comb begin
    w_used = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      w_used = w_used + CNT_W'(r_valid[i]);
    end
    w_free      = CNT_W'(ENTRIES) - w_used;
    w_dis_ready = (w_free >= CNT_W'(WAYS));
  end

  assign free_count = w_free;
  assign dis_ready  = w_dis_ready;
  assign w_ready    = r_valid & r_rs1_rdy & r_rs2_rdy;

  // Oldest-first select: each pass picks the ready candidate with no older
  // ready candidate left, then removes it from the candidate set.
  always_comb begin
    logic [ENTRIES-1:0] cand;
    cand = w_ready;
    for (int unsigned k = 0; k < WAYS; k++) begin
      w_sel_vld[k] = 1'b0;
      w_sel_idx[k] = '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        if (cand[i] && ((r_age[i] & cand) == '0)) begin
          w_sel_vld[k] = 1'b1;
          w_sel_idx[k] = IDX_W'(i);
        end
      end
      if (w_sel_vld[k]) cand[w_sel_idx[k]] = 1'b0;
    end
    w_sel_mask = w_ready & ~cand;
  end

  // Dispatch slot allocation: lowest free index, lane 0 first. The occupied
  // set seen by a lane (current valid plus earlier lanes) is exactly the set
  // of entries it is younger than.
  always_comb begin
    logic [ENTRIES-1:0] taken;
    logic               found;
    taken = r_valid;
    for (int unsigned k = 0; k < WAYS; k++) begin
      w_dis_en[k]    = 1'b0;
      w_dis_idx[k]   = '0;
      w_dis_older[k] = taken;
      found          = 1'b0;
      if (dis_valid[k] && w_dis_ready && !flush) begin
        for (int unsigned i = 0; i < ENTRIES; i++) begin
          if (!taken[i] && !found) begin
            found        = 1'b1;
            w_dis_idx[k] = IDX_W'(i);
          end
        end
        w_dis_en[k] = found;
        if (found) taken[w_dis_idx[k]] = 1'b1;
      end
    end
  end

  // Same-cycle writeback bypass for dispatched sources
  always_comb begin
    for (int unsigned k = 0; k < WAYS; k++) begin
      w_dis_rs1_rdy[k] = dis_rs1_ready[k];
      w_dis_rs2_rdy[k] = dis_rs2_ready[k];
      for (int unsigned j = 0; j < WAYS; j++) begin
        if (wb_valid[j] && (wb_index[j*PREG_W +: PREG_W] == dis_rs1[k*PREG_W +: PREG_W]))
          w_dis_rs1_rdy[k] = 1'b1;
        if (wb_valid[j] && (wb_index[j*PREG_W +: PREG_W] == dis_rs2[k*PREG_W +: PREG_W]))
          w_dis_rs2_rdy[k] = 1'b1;
      end
    end
  end

  // Entry state
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid   <= '0;
      r_rs1_rdy <= '0;
      r_rs2_rdy <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) r_age[i] <= '0;
    end else if (flush) begin
      r_valid <= '0;
    end else begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        for (int unsigned j = 0; j < WAYS; j++) begin
          if (r_valid[i] && wb_valid[j]) begin
            if (wb_index[j*PREG_W +: PREG_W] == r_rs1[i]) r_rs1_rdy[i] <= 1'b1;
            if (wb_index[j*PREG_W +: PREG_W] == r_rs2[i]) r_rs2_rdy[i] <= 1'b1;
          end
        end
        if (!iss_stall && w_sel_mask[i]) r_valid[i] <= 1'b0;
      end
      for (int unsigned k = 0; k < WAYS; k++) begin
        if (w_dis_en[k]) begin
          // Nobody is younger than a new entry: clear its column, then its row.
          for (int unsigned i = 0; i < ENTRIES; i++) r_age[i][w_dis_idx[k]] <= 1'b0;
          r_age[w_dis_idx[k]]     <= w_dis_older[k];
          r_valid[w_dis_idx[k]]   <= 1'b1;
          r_rs1[w_dis_idx[k]]     <= dis_rs1[k*PREG_W +: PREG_W];
          r_rs2[w_dis_idx[k]]     <= dis_rs2[k*PREG_W +: PREG_W];
          r_rd[w_dis_idx[k]]      <= dis_rd[k*PREG_W +: PREG_W];
          r_payload[w_dis_idx[k]] <= dis_payload[k*PAYLOAD_W +: PAYLOAD_W];
          r_rs1_rdy[w_dis_idx[k]] <= w_dis_rs1_rdy[k];
          r_rs2_rdy[w_dis_idx[k]] <= w_dis_rs2_rdy[k];
        end
      end
    end
  end

  // Issue registers
  always_ff @(posedge clock) begin
    if (reset) begin
      iss_valid     <= '0;
      iss_rs1_index <= '0;
      iss_rs2_index <= '0;
      iss_rd_index  <= '0;
      iss_payload   <= '0;
    end else if (flush) begin
      iss_valid <= '0;
    end else if (!iss_stall) begin
      for (int unsigned k = 0; k < WAYS; k++) begin
        iss_valid[k]                         <= w_sel_vld[k];
        iss_rs1_index[k*PREG_W +: PREG_W]    <= r_rs1[w_sel_idx[k]];
        iss_rs2_index[k*PREG_W +: PREG_W]    <= r_rs2[w_sel_idx[k]];
        iss_rd_index[k*PREG_W +: PREG_W]     <= r_rd[w_sel_idx[k]];
        iss_payload[k*PAYLOAD_W +: PAYLOAD_W] <= r_payload[w_sel_idx[k]];
      end
    end
  end

endmodule

// File: tb/tb_issue_queue_int.sv
// Directed table-driven bench for issue_queue_int (ENTRIES=8, WAYS=2).
// Each table row is one cycle of inputs; the expected outputs are those
// visible just after the clock edge that ends that cycle.
module tb_issue_queue_int;

  localparam int unsigned ENTRIES   = 8;
  localparam int unsigned WAYS      = 2;
  localparam int unsigned PREG_W    = 6;
  localparam int unsigned PAYLOAD_W = 32;
  localparam int          NV        = 33;

  logic                      clock = 1'b0;
  logic                      reset;
  logic                      flush;
  logic [WAYS-1:0]           dis_valid;
  logic [WAYS*PREG_W-1:0]    dis_rs1, dis_rs2, dis_rd;
  logic [WAYS-1:0]           dis_rs1_ready, dis_rs2_ready;
  logic [WAYS*PAYLOAD_W-1:0] dis_payload;
  logic                      dis_ready;
  logic [WAYS-1:0]           wb_valid;
  logic [WAYS*PREG_W-1:0]    wb_index;
  logic                      iss_stall;
  logic [WAYS-1:0]           iss_valid;
  logic [WAYS*PREG_W-1:0]    iss_rs1_index, iss_rs2_index, iss_rd_index;
  logic [WAYS*PAYLOAD_W-1:0] iss_payload;
  logic [3:0]                free_count;

  always #5 clock = ~clock;

  issue_queue_int #(
    .ENTRIES  (ENTRIES),
    .WAYS     (WAYS),
    .PREG_W   (PREG_W),
    .PAYLOAD_W(PAYLOAD_W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .flush        (flush),
    .dis_valid    (dis_valid),
    .dis_rs1      (dis_rs1),
    .dis_rs2      (dis_rs2),
    .dis_rd       (dis_rd),
    .dis_rs1_ready(dis_rs1_ready),
    .dis_rs2_ready(dis_rs2_ready),
    .dis_payload  (dis_payload),
    .dis_ready    (dis_ready),
    .wb_valid     (wb_valid),
    .wb_index     (wb_index),
    .iss_stall    (iss_stall),
    .iss_valid    (iss_valid),
    .iss_rs1_index(iss_rs1_index),
    .iss_rs2_index(iss_rs2_index),
    .iss_rd_index (iss_rd_index),
    .iss_payload  (iss_payload),
    .free_count   (free_count)
  );

  // rr: bit0 = rs1 ready, bit1 = rs2 ready. dv/wv/ev: bit per lane/slot.
  typedef struct packed {
    logic [1:0] dv;
    logic [5:0] rda, s1a, s2a;
    logic [1:0] rra;
    logic [5:0] rdb, s1b, s2b;
    logic [1:0] rrb;
    logic [1:0] wv;
    logic [5:0] wa, wb;
    logic       st, fl;
    logic [1:0] ev;
    logic [5:0] e0, e1;
    logic [3:0] efree;
    logic       edr;
  } vec_t;

  vec_t        vecs[NV];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [5:0]  lk_rs1[64];
  logic [5:0]  lk_rs2[64];
  logic [31:0] lk_pl [64];

  function automatic vec_t mk(int dv, int rda, int s1a, int s2a, int rra,
                              int rdb, int s1b, int s2b, int rrb,
                              int wv, int wa, int wb, int st, int fl,
                              int ev, int e0, int e1, int efree, int edr);
    vec_t v;
    v.dv = 2'(dv);  v.rda = 6'(rda); v.s1a = 6'(s1a); v.s2a = 6'(s2a); v.rra = 2'(rra);
    v.rdb = 6'(rdb); v.s1b = 6'(s1b); v.s2b = 6'(s2b); v.rrb = 2'(rrb);
    v.wv = 2'(wv);  v.wa = 6'(wa);   v.wb = 6'(wb);
    v.st = 1'(st);  v.fl = 1'(fl);
    v.ev = 2'(ev);  v.e0 = 6'(e0);   v.e1 = 6'(e1);
    v.efree = 4'(efree); v.edr = 1'(edr);
    return v;
  endfunction

  function automatic logic [31:0] pl_of(logic [5:0] rd);
    return 32'hBEEF_0000 | 32'(rd);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    dis_valid     = v.dv;
    dis_rd        = {v.rdb, v.rda};
    dis_rs1       = {v.s1b, v.s1a};
    dis_rs2       = {v.s2b, v.s2a};
    dis_rs1_ready = {v.rrb[0], v.rra[0]};
    dis_rs2_ready = {v.rrb[1], v.rra[1]};
    dis_payload   = {pl_of(v.rdb), pl_of(v.rda)};
    wb_valid      = v.wv;
    wb_index      = {v.wb, v.wa};
    iss_stall     = v.st;
    flush         = v.fl;
    if (v.dv[0]) begin lk_rs1[v.rda] = v.s1a; lk_rs2[v.rda] = v.s2a; lk_pl[v.rda] = pl_of(v.rda); end
    if (v.dv[1]) begin lk_rs1[v.rdb] = v.s1b; lk_rs2[v.rdb] = v.s2b; lk_pl[v.rdb] = pl_of(v.rdb); end
  endtask

  task automatic chk_slot(input string tag, input int s, input logic [5:0] erd);
    chk($sformatf("%s slot%0d rd", tag, s),  32'(iss_rd_index[s*PREG_W +: PREG_W]), 32'(erd));
    chk($sformatf("%s slot%0d rs1", tag, s), 32'(iss_rs1_index[s*PREG_W +: PREG_W]), 32'(lk_rs1[erd]));
    chk($sformatf("%s slot%0d rs2", tag, s), 32'(iss_rs2_index[s*PREG_W +: PREG_W]), 32'(lk_rs2[erd]));
    chk($sformatf("%s slot%0d payload", tag, s), iss_payload[s*PAYLOAD_W +: PAYLOAD_W], lk_pl[erd]);
  endtask

  task automatic idle();
    drive(mk(0, 0,0,0,0, 0,0,0,0, 0,0,0, 0,0, 0,0,0, 0,0));
  endtask

  initial begin
    //            dv  rdA s1 s2 rr  rdB s1 s2 rr  wv wa wb  st fl  ev e0 e1  free dr
    vecs[0]  = mk(3, 10, 3, 4, 3,  11, 3, 4, 3,  0, 0, 0,  0, 0,  0, 0, 0,  6, 1);
    vecs[1]  = mk(0,  0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,  0, 0,  3,10,11,  8, 1);
    vecs[2]  = mk(1, 12, 5, 6, 2,   0, 0, 0, 0,  0, 0, 0,  0, 0,  0, 0, 0,  7, 1);
    vecs[3]  = mk(0,  0, 0, 0, 0,   0, 0, 0, 0,  2, 0, 5,  0, 0,  0, 0, 0,  7, 1);
    vecs[4]  = mk(0,  0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,  0, 0,  1,12, 0,  8, 1);
    vecs[5]  = mk(2,  0, 0, 0, 0,  13, 8, 7, 1,  1, 7, 0,  0, 0,  0, 0, 0,  7, 1);
    vecs[6]  = mk(0,  0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,  0, 0,  1,13, 0,  8, 1);
    vecs[7]  = mk(0,  0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,  0, 0,  0, 0, 0,  8, 1);
    vecs[8]  = mk(3, 30,20,40, 2,  31,21,40, 2,  0, 0, 0,  0, 0,  0, 0, 0,  6, 1);
    vecs[9]  = mk(3, 32,22,40, 2,  33,23,40, 2,  0, 0, 0,  0, 0,  0, 0, 0,  4, 1);
    vecs[10] = mk(3, 34,24,40, 2,  35,25,40, 2,  0, 0, 0,  0, 0,  0, 0, 0,  2, 1);
    vecs[11] = mk(3, 36,26,40, 2,  37,27,40, 2,  0, 0, 0,  0, 0,  0, 0, 0,  0, 0);
    vecs[12] = mk(1, 50, 1, 2, 3,   0, 0, 0, 0,  3,21,20,  0, 0,  0, 0, 0,  0, 0);
    vecs[13] = mk(0,  0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,  0, 0,  3,30,31,  2, 1);
    vecs[14] = mk(3, 38, 1, 2, 3,  39, 1, 2, 3,  1,22, 0,  0, 0,  0, 0, 0,  0, 0);
    vecs[15] = mk(0,  0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,  0, 0,  3,32,38,  2, 1);
    vecs[16] = mk(0,  0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,  0, 0,  1,39, 0,  3, 1);
    vecs[17] = mk(1, 51, 1, 2, 3,   0, 0, 0, 0,  1,23, 0,  0, 1,  0, 0, 0,  8, 1);
    vecs[18] = mk(0,  0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,  0, 0,  0, 0, 0,  8, 1);
    vecs[19] = mk(3, 58, 1, 2, 3,  59, 1, 2, 3,  0, 0, 0,  0, 0,  0, 0, 0,  6, 1);
    vecs[20] = mk(3, 60, 1, 2, 3,  61, 1, 2, 3,  0, 0, 0,  0, 0,  3,58,59,  6, 1);
    vecs[21] = mk(1, 62, 1, 2, 3,   0, 0, 0, 0,  0, 0, 0,  1, 0,  3,58,59,  5, 1);
    vecs[22] = mk(0,  0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,  1, 0,  3,58,59,  5, 1);
    vecs[23] = mk(0,  0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,  1, 0,  3,58,59,  5, 1);
    vecs[24] = mk(0,  0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,  0, 0,  3,60,61,  7, 1);
    vecs[25] = mk(0,  0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,  0, 0,  1,62, 0,  8, 1);
    vecs[26] = mk(0,  0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,  0, 0,  0, 0, 0,  8, 1);
    vecs[27] = mk(3, 70, 1, 2, 3,  71, 1, 2, 3,  0, 0, 0,  0, 0,  0, 0, 0,  6, 1);
    vecs[28] = mk(0,  0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,  0, 0,  3,70,71,  8, 1);
    vecs[29] = mk(0,  0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,  1, 1,  0, 0, 0,  8, 1);
    vecs[30] = mk(1,  1, 0, 1, 2,   0, 0, 0, 0,  0, 0, 0,  0, 0,  0, 0, 0,  7, 1);
    vecs[31] = mk(0,  0, 0, 0, 0,   0, 0, 0, 0,  1, 0, 0,  0, 0,  0, 0, 0,  7, 1);
    vecs[32] = mk(0,  0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,  0, 0,  1, 1, 0,  8, 1);

    for (int i = 0; i < 64; i++) begin lk_rs1[i] = '0; lk_rs2[i] = '0; lk_pl[i] = '0; end

    idle();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset state
    chk("reset iss_valid", 32'(iss_valid), 32'd0);
    chk("reset iss_rd", 32'(iss_rd_index), 32'd0);
    chk("reset iss_rs1", 32'(iss_rs1_index), 32'd0);
    chk("reset iss_payload0", iss_payload[31:0], 32'd0);
    chk("reset free_count", 32'(free_count), 32'd8);
    chk("reset dis_ready", 32'(dis_ready), 32'd1);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      @(posedge clock);
      #1;
      chk($sformatf("row%0d iss_valid", i), 32'(iss_valid), 32'(vecs[i].ev));
      chk($sformatf("row%0d free_count", i), 32'(free_count), 32'(vecs[i].efree));
      chk($sformatf("row%0d dis_ready", i), 32'(dis_ready), 32'(vecs[i].edr));
      if (vecs[i].ev[0]) chk_slot($sformatf("row%0d", i), 0, vecs[i].e0);
      if (vecs[i].ev[1]) chk_slot($sformatf("row%0d", i), 1, vecs[i].e1);
    end

    // Reset in the middle of traffic clears the issue fields, not just valid
    drive(mk(3, 44, 1, 2, 3, 45, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clock); #1;
    chk("midrst pre free_count", 32'(free_count), 32'd6);
    idle();
    @(posedge clock); #1;
    chk("midrst issue valid", 32'(iss_valid), 32'd3);
    chk_slot("midrst", 0, 6'd44);
    chk_slot("midrst", 1, 6'd45);
    drive(mk(1, 46, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    idle();
    chk("midrst iss_valid", 32'(iss_valid), 32'd0);
    chk("midrst iss_rd", 32'(iss_rd_index), 32'd0);
    chk("midrst free_count", 32'(free_count), 32'd8);
    @(posedge clock); #1;
    chk("midrst after iss_valid", 32'(iss_valid), 32'd0);
    chk("midrst after free_count", 32'(free_count), 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
